// File: rtl/buffer_ctrl_pkg.sv
// rtl/buffer_ctrl_pkg.sv - shared types and sizing helpers for buffer_ctrl
// Purpose: FSM state enum, occupancy-counter width helper, stats counter width.
// Optional feature macro: BUFFER_CTRL_STATS_EN (consumed by buffer_ctrl.sv).
package buffer_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      RUN,
      DRAIN,
      DONE
   } state_e;

   localparam int STATS_W = 16;

   // Occupancy ranges over 0..mem_size inclusive, hence the +1.
   function automatic int count_width(input int mem_size);
      return $clog2(mem_size + 1);
   endfunction

endpackage

// File: rtl/buffer_ptr.sv
// rtl/buffer_ptr.sv - modulo-depth circular pointer with fixed increment
// Purpose: address pointer that wraps naturally at 2**AW (depth is a power of two).
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   clr_i  in   synchronous clear to 0 (wins over en_i)
//   en_i   in   advance by INC
//   ptr_o  out  current pointer
module buffer_ptr #(
   parameter int AW  = 3,
   parameter int INC = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [AW-1:0] ptr_o
);

   logic [AW-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (en_i) begin
         ptr_d = ptr_q + AW'(INC);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/buffer_ctrl.sv
// rtl/buffer_ctrl.sv - circular-FIFO sequencing controller for a parallel-write/parallel-read Buffer
// Purpose: drives Buffer wen/waddr/raddr; producer writes PAR_WRITE words per beat,
//   consumer takes a PAR_READ-word window and retires STRIDE words per accepted window.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a transfer (IDLE only)
//   wr_valid/wr_last      producer beat valid / final beat
//   wr_ready              beat accepted when wr_valid
//   rd_valid/rd_ready     window available / consumer accepts
//   buf_wen/waddr/raddr   Buffer control
//   count                 occupancy in words
//   busy, done            not-IDLE flag, end-of-transfer pulse
//   wr_stall_cnt, rd_stall_cnt  saturating stall counters (only with BUFFER_CTRL_STATS_EN)
module buffer_ctrl
   import buffer_ctrl_pkg::*;
#(
   parameter int SIZE        = 4,
   parameter int MEM_SIZE    = 8,
   parameter int PAR_WRITE   = 2,
   parameter int PAR_READ    = 4,
   parameter int STRIDE      = 1,
   parameter int ADDRES_SIZE = $clog2(MEM_SIZE)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               wr_valid,
   input  logic                               wr_last,
   output logic                               wr_ready,
   output logic                               rd_valid,
   input  logic                               rd_ready,
   output logic                               buf_wen,
   output logic [ADDRES_SIZE-1:0]             buf_waddr,
   output logic [ADDRES_SIZE-1:0]             buf_raddr,
   output logic [count_width(MEM_SIZE)-1:0]   count,
   output logic                               busy,
`ifdef BUFFER_CTRL_STATS_EN
   output logic [STATS_W-1:0]                 wr_stall_cnt,
   output logic [STATS_W-1:0]                 rd_stall_cnt,
`endif
   output logic                               done
);

   localparam int CW  = count_width(MEM_SIZE);
   localparam int CW1 = CW + 1;

   if (SIZE < 1 || STRIDE < 1 || STRIDE > PAR_READ ||
       MEM_SIZE < PAR_READ + PAR_WRITE - 1 || (1 << ADDRES_SIZE) != MEM_SIZE) begin : g_bad_cfg
      $error("buffer_ctrl: illegal parameter combination");
   end

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW:0]   count_w;   // one spare bit so an over/underflow is visible
   logic          wr_fire, rd_fire, accepting;

   // Handshake outputs depend only on registered state and count.
   assign accepting = (state_q == FILL) || (state_q == RUN);
   assign wr_ready  = accepting && ((CW'(MEM_SIZE) - count_q) >= CW'(PAR_WRITE));
   assign rd_valid  = (accepting || (state_q == DRAIN)) && (count_q >= CW'(PAR_READ));
   assign buf_wen   = wr_valid & wr_ready;
   assign wr_fire   = buf_wen;
   assign rd_fire   = rd_valid & rd_ready;

   assign count_w = {1'b0, count_q}
                  + (wr_fire ? CW1'(PAR_WRITE) : '0)
                  - (rd_fire ? CW1'(STRIDE)    : '0);

   always_comb begin
      state_d = state_q;
      count_d = count_w[CW-1:0];
      case (state_q)
         IDLE:  if (start) state_d = FILL;
         FILL, RUN: begin
            if (wr_fire && wr_last) begin
               state_d = DRAIN;
            end else if (state_q == FILL && count_w >= CW1'(PAR_READ)) begin
               state_d = RUN;
            end else if (state_q == RUN && count_w < CW1'(PAR_READ)) begin
               state_d = FILL;
            end
         end
         DRAIN: if (count_w < CW1'(PAR_READ)) state_d = DONE;
         DONE: begin
            // Any sub-window tail is dropped here.
            state_d = IDLE;
            count_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   buffer_ptr #(.AW(ADDRES_SIZE), .INC(PAR_WRITE)) u_wptr (
      .clk   (clk),
      .rst   (rst),
      .clr_i (state_q == DONE),
      .en_i  (wr_fire),
      .ptr_o (buf_waddr)
   );

   buffer_ptr #(.AW(ADDRES_SIZE), .INC(STRIDE)) u_rptr (
      .clk   (clk),
      .rst   (rst),
      .clr_i (state_q == DONE),
      .en_i  (rd_fire),
      .ptr_o (buf_raddr)
   );

   assign count = count_q;
   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);

`ifdef BUFFER_CTRL_STATS_EN
   logic [STATS_W-1:0] wr_stall_q, rd_stall_q;

   always_ff @(posedge clk) begin
      if (rst || start) begin
         wr_stall_q <= '0;
         rd_stall_q <= '0;
      end else begin
         if (wr_valid && !wr_ready && busy && wr_stall_q != '1) wr_stall_q <= wr_stall_q + 1'b1;
         if (rd_valid && !rd_ready && rd_stall_q != '1)          rd_stall_q <= rd_stall_q + 1'b1;
      end
   end

   assign wr_stall_cnt = wr_stall_q;
   assign rd_stall_cnt = rd_stall_q;
`endif

   // Occupancy must stay within 0..MEM_SIZE; an underflow wraps into the spare bit range.
   a_count_range: assert property (@(posedge clk) disable iff (rst) count_w <= CW1'(MEM_SIZE));

endmodule

// File: tb/tb_buffer_ctrl.sv
// tb/tb_buffer_ctrl.sv - scoreboard bench for buffer_ctrl with word-queue reference model
module tb_buffer_ctrl;
   import buffer_ctrl_pkg::*;

   localparam int SIZE = 4, MEM = 8, PW = 2, PR = 4, STR = 1, AW = 3, CW = 4;

   logic clk = 1'b0;
   logic rst, start, wr_valid, wr_last, rd_ready;
   logic wr_ready, rd_valid, buf_wen, busy, done;
   logic [AW-1:0] buf_waddr, buf_raddr;
   logic [CW-1:0] count;
`ifdef BUFFER_CTRL_STATS_EN
   logic [15:0] wr_stall_cnt, rd_stall_cnt;
   int m_wst = 0, m_rst = 0;
`endif

   always #5 clk = ~clk;

   buffer_ctrl #(.SIZE(SIZE), .MEM_SIZE(MEM), .PAR_WRITE(PW), .PAR_READ(PR),
                 .STRIDE(STR), .ADDRES_SIZE(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .wr_valid(wr_valid), .wr_last(wr_last),
      .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_ready(rd_ready), .buf_wen(buf_wen),
      .buf_waddr(buf_waddr), .buf_raddr(buf_raddr), .count(count), .busy(busy),
`ifdef BUFFER_CTRL_STATS_EN
      .wr_stall_cnt(wr_stall_cnt), .rd_stall_cnt(rd_stall_cnt),
`endif
      .done(done)
   );

   // Buffer stand-in: producer din lands at the controller's waddr.
   logic [SIZE-1:0] mem [MEM];
   logic [SIZE-1:0] din [PW];
   always @(posedge clk)
      if (buf_wen) for (int k = 0; k < PW; k++) mem[(int'(buf_waddr) + k) % MEM] <= din[k];

   // Reference model: FIFO of words in flight plus a coarse transfer phase.
   typedef enum {M_IDLE, M_ACT, M_DRAIN, M_DONE} mode_t;
   mode_t mode = M_IDLE;
   logic [SIZE-1:0] q[$];
   int wp = 0, rp = 0, beats = 0, seq = 0;
   int checks = 0, errors = 0;
   bit mon_en = 0;

   function automatic bit m_ready();
      return mode == M_ACT && (MEM - q.size()) >= PW;
   endfunction
   function automatic bit m_rv();
      return (mode == M_ACT || mode == M_DRAIN) && q.size() >= PR;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit fw, fr;
      fw = wr_valid && m_ready();
      fr = rd_ready && m_rv();
      if (rst) begin
         mode = M_IDLE; q.delete(); wp = 0; rp = 0;
`ifdef BUFFER_CTRL_STATS_EN
         m_wst = 0; m_rst = 0;
`endif
      end else if (mon_en) begin
         chk("buf_wen", buf_wen, fw);
`ifdef BUFFER_CTRL_STATS_EN
         if (start) begin m_wst = 0; m_rst = 0; end
         else begin
            if (wr_valid && !m_ready() && mode != M_IDLE) m_wst++;
            if (m_rv() && !rd_ready) m_rst++;
         end
`endif
         if (fw) begin
            for (int k = 0; k < PW; k++) q.push_back(SIZE'(seq + k));
            seq += PW; wp = (wp + PW) % MEM; beats++;
         end
         if (fr) begin
            for (int k = 0; k < STR; k++) void'(q.pop_front());
            rp = (rp + STR) % MEM;
         end
         case (mode)
            M_IDLE:  if (start) begin mode = M_ACT; beats = 0; end
            M_ACT:   if (fw && wr_last) mode = M_DRAIN;
            M_DRAIN: if (q.size() < PR) mode = M_DONE;
            M_DONE:  begin mode = M_IDLE; q.delete(); wp = 0; rp = 0; end
         endcase
      end
   end

   // Monitor: compares visible outputs and, whenever a window is presented, its contents.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("count", count, q.size());
         chk("rd_valid", rd_valid, m_rv());
         chk("wr_ready", wr_ready, m_ready());
         chk("busy", busy, mode != M_IDLE);
         chk("done", done, mode == M_DONE);
         chk("waddr", buf_waddr, wp);
         chk("raddr", buf_raddr, rp);
         if (rd_valid && m_rv())
            for (int k = 0; k < PR; k++)
               chk("window", mem[(int'(buf_raddr) + k) % MEM], q[k]);
`ifdef BUFFER_CTRL_STATS_EN
         chk("wr_stall_cnt", wr_stall_cnt, m_wst);
         chk("rd_stall_cnt", rd_stall_cnt, m_rst);
`endif
      end
   end

   task automatic tick();
      @(negedge clk); #1;
      for (int k = 0; k < PW; k++) din[k] = SIZE'(seq + k);
   endtask

   task automatic run_transfer(input int nbeats, input bit do_rst);
      int cyc, rst_at;
      rst_at = $urandom_range(2, 10);
      start = 1; tick(); start = 0;
      cyc = 0;
      while (mode == M_ACT && cyc < 300) begin
         wr_valid = ($urandom % 4) != 0;
         wr_last  = beats >= nbeats - 1;
         rd_ready = ($urandom % 3) != 0;
         rst      = do_rst && cyc == rst_at;
         tick();
         rst = 0;
         cyc++;
      end
      wr_valid = 0; wr_last = 0;
      while (mode != M_IDLE && cyc < 600) begin
         rd_ready = ($urandom % 3) != 0;
         start    = ($urandom % 5) == 0;   // must be ignored outside IDLE
         tick();
         cyc++;
      end
      start = 0; rd_ready = 0;
      if (cyc >= 600) chk("transfer_timeout", cyc, 0);
   endtask

   initial begin
      int n;
      rst = 1; start = 0; wr_valid = 0; wr_last = 0; rd_ready = 0;
      for (int k = 0; k < PW; k++) din[k] = '0;
      @(posedge clk); mon_en = 1;
      repeat (2) tick();
      chk("reset_count", count, 0);
      chk("reset_busy", busy, 0);
      chk("reset_wr_ready", wr_ready, 0);
      rst = 0;

      // Two beats, no reads.
      start = 1; tick(); start = 0;
      wr_valid = 1; tick(); tick(); wr_valid = 0;
      chk("p1_count", count, 4);
      chk("p1_waddr", buf_waddr, 4);
      chk("p1_rd_valid", rd_valid, 1);
      chk("p1_raddr", buf_raddr, 0);
      chk("p1_state_run", int'(dut.state_q), int'(RUN));

      // Fill to capacity, then hold a beat that must not be written.
      wr_valid = 1; tick(); tick();
      chk("p2_count_full", count, 8);
      chk("p2_wr_ready", wr_ready, 0);
      tick(); tick(); tick();
      chk("p2_count_held", count, 8);

      // Continuous write and read across the wrap.
      rd_ready = 1;
      repeat (12) tick();
      wr_last = 1;
      n = 0;
      while (mode == M_ACT && n < 20) begin tick(); n++; end
      wr_valid = 0; wr_last = 0;
      tick(); start = 1; tick(); start = 0;
      n = 0;
      while (mode != M_IDLE && n < 50) begin tick(); n++; end
      chk("p3_back_idle", busy, 0);
      rd_ready = 0;

      // Reset in RUN with count 6.
      start = 1; tick(); start = 0;
      wr_valid = 1; repeat (3) tick(); wr_valid = 0;
      chk("p4_count6", count, 6);
      rst = 1; tick(); rst = 0;
      chk("p4_rst_count", count, 0);
      chk("p4_rst_busy", busy, 0);

      for (int t = 0; t < 40; t++)
         run_transfer($urandom_range(1, 10), ($urandom % 6) == 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
